line_dma_scheduler: RTL and testbench

- Ping-pong linebuffer scheduler between the pixel-side linebuffer writer and the processing-system DMA engine.
- Tracks which of two linebuffer banks holds a completed line and tells the writer which bank to fill next.
- Issues one DMA request per line with source bank address, framebuffer destination and word count.
- Raises line/frame interrupts and flags overflow when the writer outruns the DMA.

---
 rtl/line_dma_scheduler.sv | 193 +++++++++++++++++++
 tb/tb_line_dma_scheduler.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_dma_scheduler.sv
// Ping-pong linebuffer scheduler: tracks two bank-full flags, hands completed
// lines to the DMA engine and raises line/frame interrupts. Optional macro DROP_COUNT_EN.
module line_dma_scheduler #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int BANK_WORDS    = 1024,
  parameter int LEN_WIDTH     = 11,
  parameter int FRAME_LINES   = 720
) (
  input  logic                     pclk,
  input  logic                     reset,
  input  logic                     frame_start,
  input  logic                     line_done,
  input  logic [LEN_WIDTH-1:0]     line_words,
  input  logic [31:0]              fb_base,
  input  logic [15:0]              fb_stride,
  output logic                     wr_bank,
  output logic [ADDRESS_WIDTH-1:0] wr_base,
  output logic                     dma_req,
  output logic [ADDRESS_WIDTH-1:0] dma_src,
  output logic [31:0]              dma_dst,
  output logic [LEN_WIDTH-1:0]     dma_len,
  input  logic                     dma_ack,
  input  logic                     dma_done,
  output logic                     line_irq,
  output logic                     frame_irq,
  output logic                     overflow,
  output logic                     busy
`ifdef DROP_COUNT_EN
  ,
  output logic [15:0]              drop_count
`endif
);

  localparam int IDX_W = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LINES - 1);
  localparam logic [ADDRESS_WIDTH-1:0] BANK1_BASE = ADDRESS_WIDTH'(BANK_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [1:0]           full_q, full_d;
  logic [1:0]           last_q, last_d;
  logic [LEN_WIDTH-1:0] len_q [2];
  logic [LEN_WIDTH-1:0] len_d [2];
  logic [31:0]          dst_q [2];
  logic [31:0]          dst_d [2];
  logic                 wr_bank_q, wr_bank_d;
  logic                 rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0]     line_idx_q, line_idx_d;
  logic [31:0]          line_addr_q, line_addr_d;
  logic                 overflow_q, overflow_d;
`ifdef DROP_COUNT_EN
  logic [15:0]          drop_q, drop_d;
  logic [15:0]          drop_cur;
`endif

  logic                 line_irq_c;
  logic                 frame_irq_c;
  logic [31:0]          cur_addr;
  logic [IDX_W-1:0]     cur_idx;
  logic                 is_last;

  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q     <= IDLE;
      full_q      <= '0;
      last_q      <= '0;
      len_q[0]    <= '0;
      len_q[1]    <= '0;
      dst_q[0]    <= '0;
      dst_q[1]    <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      line_idx_q  <= '0;
      line_addr_q <= '0;
      overflow_q  <= 1'b0;
`ifdef DROP_COUNT_EN
      drop_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      full_q      <= full_d;
      last_q      <= last_d;
      len_q[0]    <= len_d[0];
      len_q[1]    <= len_d[1];
      dst_q[0]    <= dst_d[0];
      dst_q[1]    <= dst_d[1];
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      line_idx_q  <= line_idx_d;
      line_addr_q <= line_addr_d;
      overflow_q  <= overflow_d;
`ifdef DROP_COUNT_EN
      drop_q      <= drop_d;
`endif
    end
  end

  // DMA side runs first so a same-cycle dma_done frees its bank before the writer checks it.
  always_comb begin
    state_d     = state_q;
    full_d      = full_q;
    last_d      = last_q;
    len_d[0]    = len_q[0];
    len_d[1]    = len_q[1];
    dst_d[0]    = dst_q[0];
    dst_d[1]    = dst_q[1];
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    line_idx_d  = line_idx_q;
    line_addr_d = line_addr_q;
    overflow_d  = overflow_q;
    line_irq_c  = 1'b0;
    frame_irq_c = 1'b0;
`ifdef DROP_COUNT_EN
    drop_d      = drop_q;
    drop_cur    = frame_start ? 16'h0000 : drop_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (full_q[rd_bank_q]) state_d = REQ;
      end
      REQ: begin
        if (dma_ack) state_d = XFER;
      end
      XFER: begin
        if (dma_done) begin
          state_d           = IDLE;
          full_d[rd_bank_q] = 1'b0;
          rd_bank_d         = ~rd_bank_q;
          line_irq_c        = 1'b1;
          frame_irq_c       = last_q[rd_bank_q];
        end
      end
      default: state_d = IDLE;
    endcase

    // A frame_start coinciding with line_done makes that line row 0 of the new frame.
    cur_addr = frame_start ? fb_base : line_addr_q;
    cur_idx  = frame_start ? '0 : line_idx_q;
    is_last  = (cur_idx == LAST_IDX);

    if (frame_start) begin
      line_addr_d = fb_base;
      line_idx_d  = '0;
      overflow_d  = 1'b0;
`ifdef DROP_COUNT_EN
      drop_d      = 16'h0000;
`endif
    end

    if (line_done) begin
      line_addr_d = cur_addr + {16'h0000, fb_stride};
      line_idx_d  = is_last ? cur_idx : cur_idx + 1'b1;
      if (line_words == '0) begin
        if (is_last) frame_irq_c = 1'b1;
      end else if (full_d[wr_bank_q]) begin
        overflow_d = 1'b1;
        if (is_last) frame_irq_c = 1'b1;
`ifdef DROP_COUNT_EN
        drop_d = (drop_cur == 16'hFFFF) ? drop_cur : drop_cur + 16'h0001;
`endif
      end else begin
        full_d[wr_bank_q] = 1'b1;
        len_d[wr_bank_q]  = line_words;
        dst_d[wr_bank_q]  = cur_addr;
        last_d[wr_bank_q] = is_last;
        wr_bank_d         = ~wr_bank_q;
      end
    end
  end

  assign wr_bank   = wr_bank_q;
  assign wr_base   = wr_bank_q ? BANK1_BASE : '0;
  assign dma_req   = (state_q == REQ);
  assign dma_src   = rd_bank_q ? BANK1_BASE : '0;
  assign dma_dst   = dst_q[rd_bank_q];
  assign dma_len   = len_q[rd_bank_q];
  // Interrupts follow the triggering input directly; masked while reset is held.
  assign line_irq  = line_irq_c & ~reset;
  assign frame_irq = frame_irq_c & ~reset;
  assign overflow  = overflow_q;
  assign busy      = (state_q != IDLE) | (|full_q);
`ifdef DROP_COUNT_EN
  assign drop_count = drop_q;
`endif

endmodule

// File: tb/tb_line_dma_scheduler.sv
// Self-checking bench for line_dma_scheduler: directed scenarios plus a random
// phase, checked against a queue-based reference model of the two-bank scheduler.
module tb_line_dma_scheduler;

  localparam int FL = 4;
  localparam int LW = 11;

  logic          pclk = 1'b0;
  logic          reset = 1'b1;
  logic          frame_start = 1'b0;
  logic          line_done = 1'b0;
  logic [LW-1:0] line_words = '0;
  logic [31:0]   fb_base = '0;
  logic [15:0]   fb_stride = '0;
  logic          wr_bank;
  logic [15:0]   wr_base;
  logic          dma_req;
  logic [15:0]   dma_src;
  logic [31:0]   dma_dst;
  logic [LW-1:0] dma_len;
  logic          dma_ack = 1'b0;
  logic          dma_done = 1'b0;
  logic          line_irq;
  logic          frame_irq;
  logic          overflow;
  logic          busy;
`ifdef DROP_COUNT_EN
  logic [15:0]   drop_count;
`endif

  line_dma_scheduler #(
    .ADDRESS_WIDTH(16),
    .BANK_WORDS(1024),
    .LEN_WIDTH(LW),
    .FRAME_LINES(FL)
  ) dut (
    .pclk(pclk),
    .reset(reset),
    .frame_start(frame_start),
    .line_done(line_done),
    .line_words(line_words),
    .fb_base(fb_base),
    .fb_stride(fb_stride),
    .wr_bank(wr_bank),
    .wr_base(wr_base),
    .dma_req(dma_req),
    .dma_src(dma_src),
    .dma_dst(dma_dst),
    .dma_len(dma_len),
    .dma_ack(dma_ack),
    .dma_done(dma_done),
    .line_irq(line_irq),
    .frame_irq(frame_irq),
    .overflow(overflow),
    .busy(busy)
`ifdef DROP_COUNT_EN
    ,
    .drop_count(drop_count)
`endif
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic [15:0]   src;
    logic [31:0]   dst;
    logic [LW-1:0] len;
    bit            last;
  } xfer_t;

  // Reference model: queued lines in completion order, writer bank, frame cursor.
  xfer_t       q[$];
  bit          mWrBank = 1'b0;
  logic [31:0] mAddr = '0;
  int          mIdx = 0;
  bit          mOverflow = 1'b0;
  bit          mInflight = 1'b0;
  int          mDrop = 0;

  int          checks = 0;
  int          errors = 0;
  int          reqWait = 0;
  int          lineIrqCnt = 0;
  int          frameIrqCnt = 0;
  int          bothCnt = 0;
  bit          lastReq = 1'b0;
  logic [31:0] fbBase = '0;
  logic [15:0] fbStride = '0;
  logic [31:0] ackDst = '0;
  logic [15:0] ackSrc = '0;
  logic [LW-1:0] ackLen = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check registered outputs, drive inputs, advance the model, check irqs.
  task automatic step(input bit rst, input bit ld, input int words, input bit fs,
                      input bit ack, input bit done);
    bit sawReq;
    bit expLine;
    bit expFrame;
    bit last;
    @(negedge pclk);
    sawReq = dma_req;
    lastReq = sawReq;
    check("busy", 64'(busy), 64'(q.size() != 0));
    check("wr_bank", 64'(wr_bank), 64'(mWrBank));
    check("wr_base", 64'(wr_base), mWrBank ? 64'd1024 : 64'd0);
    check("overflow", 64'(overflow), 64'(mOverflow));
`ifdef DROP_COUNT_EN
    check("drop_count", 64'(drop_count), 64'(mDrop));
`endif
    if (q.size() == 0 || mInflight) check("req_quiet", 64'(dma_req), 64'd0);
    if (dma_req === 1'b1 && q.size() != 0) begin
      check("dma_src", 64'(dma_src), 64'(q[0].src));
      check("dma_dst", 64'(dma_dst), 64'(q[0].dst));
      check("dma_len", 64'(dma_len), 64'(q[0].len));
    end
    if (q.size() != 0 && !mInflight && dma_req !== 1'b1) reqWait++;
    else reqWait = 0;
    check("req_latency", 64'(reqWait <= 3), 64'd1);

    reset       = rst;
    line_done   = ld;
    line_words  = LW'(words);
    frame_start = fs;
    dma_ack     = ack;
    dma_done    = done;
    fb_base     = fbBase;
    fb_stride   = fbStride;
    #1;

    expLine  = 1'b0;
    expFrame = 1'b0;
    if (rst) begin
      q.delete();
      mWrBank = 1'b0; mAddr = '0; mIdx = 0; mOverflow = 1'b0; mInflight = 1'b0; mDrop = 0;
    end else begin
      if (done && mInflight) begin
        expLine  = 1'b1;
        expFrame = q[0].last;
        void'(q.pop_front());
        mInflight = 1'b0;
      end
      if (ack && sawReq && q.size() != 0) begin
        mInflight = 1'b1;
        ackDst = q[0].dst;
        ackSrc = q[0].src;
        ackLen = q[0].len;
      end
      if (fs) begin
        mAddr = fbBase; mIdx = 0; mOverflow = 1'b0; mDrop = 0;
      end
      if (ld) begin
        last = (mIdx == FL - 1);
        if (words == 0) begin
          if (last) expFrame = 1'b1;
        end else if (q.size() == 2) begin
          mOverflow = 1'b1;
          if (mDrop < 65535) mDrop++;
          if (last) expFrame = 1'b1;
        end else begin
          q.push_back('{src: (mWrBank ? 16'd1024 : 16'd0), dst: mAddr, len: LW'(words), last: last});
          mWrBank = ~mWrBank;
        end
        mAddr = mAddr + {16'h0000, fbStride};
        if (mIdx < FL - 1) mIdx++;
      end
    end
    check("line_irq", 64'(line_irq), 64'(expLine));
    check("frame_irq", 64'(frame_irq), 64'(expFrame));
    if (line_irq === 1'b1) lineIrqCnt++;
    if (frame_irq === 1'b1) frameIrqCnt++;
    if (line_irq === 1'b1 && frame_irq === 1'b1) bothCnt++;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic lineIn(input int words);
    step(1'b0, 1'b1, words, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic waitAck();
    for (int i = 0; i < 10 && !mInflight; i++) step(1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    check("ack_taken", 64'(mInflight), 64'd1);
  endtask

  task automatic serviceOne();
    waitAck();
    idle();
    step(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lineBase;
    int frameBase;
    int bothBase;
    bit rs, ld, fs, ak, dn;
    int words;
    int rr;

    step(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    idle();
    check("rst_req", 64'(dma_req), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);

    // Three prompt lines, then a fourth that completes the frame.
    fbBase = 32'h1000_0000;
    fbStride = 16'd2560;
    step(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
    lineBase = lineIrqCnt;
    frameBase = frameIrqCnt;
    bothBase = bothCnt;
    lineIn(480); serviceOne();
    check("s1_dst0", 64'(ackDst), 64'h1000_0000);
    check("s1_src0", 64'(ackSrc), 64'd0);
    check("s1_len0", 64'(ackLen), 64'd480);
    lineIn(480); serviceOne();
    check("s1_dst1", 64'(ackDst), 64'h1000_0A00);
    check("s1_src1", 64'(ackSrc), 64'd1024);
    lineIn(480); serviceOne();
    check("s1_dst2", 64'(ackDst), 64'h1000_1400);
    check("s1_src2", 64'(ackSrc), 64'd0);
    check("s1_lineirqs", 64'(lineIrqCnt - lineBase), 64'd3);
    check("s1_noframe", 64'(frameIrqCnt - frameBase), 64'd0);
    lineIn(480); serviceOne();
    check("s1_frameirq", 64'(frameIrqCnt - frameBase), 64'd1);
    check("s1_frame_with_line", 64'(bothCnt - bothBase), 64'd1);

    // Stalled DMA: third line dropped.
    step(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
    lineIn(100); idle();
    lineIn(101); idle();
    lineIn(102); idle();
    check("s2_overflow", 64'(overflow), 64'd1);
    check("s2_wrbank", 64'(wr_bank), 64'd0);
    serviceOne();
    serviceOne();
    lineIn(103); serviceOne();
    check("s2_dst3", 64'(ackDst), 64'h1000_0000 + 64'd3 * 64'd2560);

    // frame_start while a transfer is in flight.
    lineIn(64);
    waitAck();
    check("s5_olddst", 64'(ackDst), 64'h1000_0000 + 64'd4 * 64'd2560);
    fbBase = 32'h2000_0000;
    step(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    check("s5_ovf_clear", 64'(overflow), 64'd0);
    lineIn(32); serviceOne();
    check("s5_newdst", 64'(ackDst), 64'h2000_0000);

    // Same-cycle dma_done and line_done with both banks full.
    step(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
    lineIn(200);
    lineIn(201);
    waitAck();
    idle();
    step(1'b0, 1'b1, 202, 1'b0, 1'b0, 1'b1);
    idle();
    check("s3_no_ovf", 64'(overflow), 64'd0);
    serviceOne();
    serviceOne();
    check("s3_len", 64'(ackLen), 64'd202);

    // Reset while requesting; a later stray dma_done is ignored.
    lineIn(50);
    for (int i = 0; i < 10 && !lastReq; i++) idle();
    lineBase = lineIrqCnt;
    step(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    check("s6_req", 64'(dma_req), 64'd0);
    idle();
    check("s6_noirq", 64'(lineIrqCnt - lineBase), 64'd0);

    // Random traffic with stray acks/dones, zero-length lines and occasional resets.
    repeat (600) begin
      rr = int'($urandom_range(0, 199));
      rs = (rr == 199);
      fs = (rr < 6);
      if (fs) begin
        fbBase = $urandom;
        fbStride = 16'($urandom);
      end
      ld = ($urandom_range(0, 3) == 0);
      words = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 2047));
      ak = ($urandom_range(0, 1) == 1);
      dn = ($urandom_range(0, 2) == 0);
      step(rs, ld, words, fs, ak, dn);
    end
    for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 0, 1'b0, 1'b1, (i % 2) == 1);
    check("drain_busy", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
